// File: rtl/sdram_pkg.sv
// sdram_pkg: shared types and constants for the SDRAM read-side pixel buffer
package sdram_pkg;
  typedef enum logic [1:0] {INIT, FLOW, PAUSED} flow_state_t;
  localparam int SDRAM_DATA_W = 16;
  localparam int SDRAM_BURST_LEN = 2;
endpackage

// File: rtl/pixel_fifo_mem.sv
// pixel_fifo_mem: DEPTH-1 x DATA_W simple dual-port RAM, registered read
module pixel_fifo_mem #(
  parameter int DEPTH = 64,
  parameter int DATA_W = 16,
  localparam int AW = $clog2(DEPTH)
)(
  input  logic              ck143,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH-1];
  always_ff @(posedge ck143) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/sdram_pixel_buffer.sv
// sdram_pixel_buffer: show-ahead FIFO between SDRAM reads and the pixel pipeline
// with watermark pause/unpause pulses; SDRAM_BUF_STATS_EN adds overflow statistics
module sdram_pixel_buffer import sdram_pkg::*; #(
  parameter int DEPTH = 64,
  parameter int DATA_W = SDRAM_DATA_W,
  parameter int HIGH_WM = DEPTH - 2 * SDRAM_BURST_LEN,
  parameter int LOW_WM = DEPTH / 2,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
)(
  input  logic              ck143,
  input  logic              reset_n,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              pause,
  output logic              unpause,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
`ifdef SDRAM_BUF_STATS_EN
  output logic              ovf_sticky,
  output logic [15:0]       drop_cnt,
`endif
  output logic [LW-1:0]     level
);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [LW-1:0] HI = LW'(HIGH_WM);
  localparam logic [LW-1:0] LO = LW'(LOW_WM);
  localparam logic [AW-1:0] PLAST = AW'(DEPTH - 2);
  flow_state_t r_state, w_state_nxt;
  logic r_pause, r_unpause, w_pause, w_unpause;
  logic r_valid, r_byp;
  logic [DATA_W-1:0] r_data, r_byp_d, w_ram_q, w_mem_q;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
  logic [LW-1:0] r_level, w_level_nxt;
  logic w_push, w_pop, w_mem_empty, w_to_out, w_wr, w_rd;
  assign w_pop = r_valid & pix_ready;
  assign w_push = rd_valid & (r_level != FULL);
  assign w_mem_empty = (r_level - LW'(r_valid)) == '0;
  assign w_to_out = w_push & (!r_valid | (w_pop & w_mem_empty));
  assign w_wr = w_push & !w_to_out;
  assign w_rd = w_pop & !w_mem_empty;
  assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
  assign w_rd_ptr_nxt = w_rd ? (r_rd_ptr == PLAST ? '0 : r_rd_ptr + 1'b1) : r_rd_ptr;
  // RAM is addressed with the upcoming read pointer; a same-edge write to that slot is bypassed
  assign w_mem_q = r_byp ? r_byp_d : w_ram_q;
  pixel_fifo_mem #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_mem (
    .ck143   (ck143),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata (rd_data),
    .i_raddr (w_rd_ptr_nxt),
    .o_rdata (w_ram_q)
  );
  always_ff @(posedge ck143 or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level <= '0;
      r_byp <= 1'b0;
      r_byp_d <= '0;
    end else begin
      r_valid <= w_rd | w_to_out | (r_valid & !w_pop);
      if (w_rd) r_data <= w_mem_q;
      else if (w_to_out) r_data <= rd_data;
      if (w_wr) r_wr_ptr <= r_wr_ptr == PLAST ? '0 : r_wr_ptr + 1'b1;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_level <= w_level_nxt;
      r_byp <= w_wr & (r_wr_ptr == w_rd_ptr_nxt);
      r_byp_d <= rd_data;
    end
  end
  always_ff @(posedge ck143 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= INIT;
      r_pause <= 1'b0;
      r_unpause <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pause <= w_pause;
      r_unpause <= w_unpause;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_pause = 1'b0;
    w_unpause = 1'b0;
    case (r_state)
      INIT: begin
        w_unpause = 1'b1;
        w_state_nxt = FLOW;
      end
      FLOW: if (w_level_nxt >= HI) begin
        w_pause = 1'b1;
        w_state_nxt = PAUSED;
      end
      PAUSED: if (w_level_nxt <= LO) begin
        w_unpause = 1'b1;
        w_state_nxt = FLOW;
      end
      default: w_state_nxt = INIT;
    endcase
  end
`ifdef SDRAM_BUF_STATS_EN
  logic w_drop, r_ovf;
  logic [15:0] r_drop;
  assign w_drop = rd_valid & (r_level == FULL);
  always_ff @(posedge ck143 or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
      r_drop <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (r_drop != 16'hFFFF) r_drop <= r_drop + 1'b1;
    end
  end
  assign ovf_sticky = r_ovf;
  assign drop_cnt = r_drop;
`endif
  assign pause = r_pause;
  assign unpause = r_unpause;
  assign pix_valid = r_valid;
  assign pix_data = r_data;
  assign level = r_level;
endmodule

// File: tb/tb_sdram_pixel_buffer.sv
// tb_sdram_pixel_buffer: directed self-checking bench for sdram_pixel_buffer (DEPTH=64)
module tb_sdram_pixel_buffer;
  logic ck143 = 1'b0;
  logic reset_n, rd_valid, pix_ready;
  logic [15:0] rd_data;
  logic pause, unpause, pix_valid;
  logic [15:0] pix_data;
  logic [6:0] level;
`ifdef SDRAM_BUF_STATS_EN
  logic ovf_sticky;
  logic [15:0] drop_cnt;
`endif
  int n_vec = 0;
  int n_err = 0;
  always #5 ck143 = ~ck143;
  sdram_pixel_buffer dut (
    .ck143     (ck143),
    .reset_n   (reset_n),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .pause     (pause),
    .unpause   (unpause),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
`ifdef SDRAM_BUF_STATS_EN
    .ovf_sticky(ovf_sticky),
    .drop_cnt  (drop_cnt),
`endif
    .level     (level)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge ck143);
    #1;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_pause"}, 32'(pause), 0);
    chk({tag, "_unpause"}, 32'(unpause), 0);
    chk({tag, "_valid"}, 32'(pix_valid), 0);
    chk({tag, "_data"}, 32'(pix_data), 0);
    chk({tag, "_level"}, 32'(level), 0);
  endtask
  initial begin
    reset_n = 1'b0;
    rd_valid = 1'b0;
    pix_ready = 1'b0;
    rd_data = '0;
    #12;
    chk_idle("rst");
    reset_n = 1'b1;
    #1;
    chk_idle("rel");
    step();
    chk("first_unpause", 32'(unpause), 1);
    chk("first_pause", 32'(pause), 0);
    step();
    chk("unpause_1cyc", 32'(unpause), 0);
    rd_valid = 1'b1;
    rd_data = 16'hA5A5;
    step();
    chk("single_valid", 32'(pix_valid), 1);
    chk("single_data", 32'(pix_data), 32'hA5A5);
    chk("single_level", 32'(level), 1);
    rd_valid = 1'b0;
    pix_ready = 1'b1;
    step();
    chk("pop_level", 32'(level), 0);
    chk("pop_valid", 32'(pix_valid), 0);
    pix_ready = 1'b0;
    rd_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      rd_data = 16'(i);
      step();
      chk("fill_level", 32'(level), 32'(i + 1));
      chk("fill_pause", 32'(pause), 32'(i + 1 == 60));
      chk("fill_unpause", 32'(unpause), 0);
    end
    rd_data = 16'hFFFF;
    step();
    chk("full_level", 32'(level), 64);
    chk("full_pause", 32'(pause), 0);
`ifdef SDRAM_BUF_STATS_EN
    chk("ovf_sticky", 32'(ovf_sticky), 1);
    chk("drop_cnt", 32'(drop_cnt), 1);
`endif
    rd_valid = 1'b0;
    pix_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      chk("drain_valid", 32'(pix_valid), 1);
      chk("drain_data", 32'(pix_data), 32'(i));
      step();
      chk("drain_level", 32'(level), 32'(63 - i));
      chk("drain_unpause", 32'(unpause), 32'(63 - i == 32));
      chk("drain_pause", 32'(pause), 0);
    end
    chk("drain_empty", 32'(pix_valid), 0);
    pix_ready = 1'b0;
    rd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rd_data = 16'(100 + i);
      step();
    end
    chk("ss_level0", 32'(level), 10);
    pix_ready = 1'b1;
    for (int j = 0; j < 100; j++) begin
      rd_data = 16'(200 + j);
      chk("ss_data", 32'(pix_data), j < 10 ? 32'(100 + j) : 32'(190 + j));
      step();
      chk("ss_level", 32'(level), 10);
      chk("ss_pulses", {30'b0, pause, unpause}, 0);
    end
    pix_ready = 1'b0;
    for (int i = 0; i < 52; i++) begin
      rd_data = 16'(300 + i);
      step();
      chk("refill_pause", 32'(pause), 32'(level == 60));
    end
    chk("refill_level", 32'(level), 62);
    rd_valid = 1'b0;
    pix_ready = 1'b1;
    for (int i = 0; i < 22; i++) begin
      step();
      chk("down_unpause", 32'(unpause), 0);
    end
    chk("down_level", 32'(level), 40);
    pix_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk_idle("async_rst");
    reset_n = 1'b1;
    step();
    chk("post_rst_unpause", 32'(unpause), 1);
    chk("post_rst_level", 32'(level), 0);
    rd_valid = 1'b1;
    rd_data = 16'h1111;
    step();
    rd_data = 16'h2222;
    step();
    chk("byp_level", 32'(level), 2);
    rd_valid = 1'b0;
    pix_ready = 1'b1;
    chk("byp_head", 32'(pix_data), 32'h1111);
    step();
    chk("byp_next", 32'(pix_data), 32'h2222);
    chk("byp_valid", 32'(pix_valid), 1);
    step();
    chk("byp_empty", 32'(pix_valid), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
